// File: rtl/bus_pkg.sv
// Shared types and constants for the host register port (bus_reg_port).
// Optional build macro BUS_ERR_COUNT_EN enables the illegal-access counter.
package bus_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RW_BIT = 31;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [IDX_W-1:0]  ERR_CNT_IDX   = 8'hFF;
  localparam logic [DATA_W-1:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HAVE_ADDR = 2'd1,
    DRIVE     = 2'd2
  } bus_port_state_t;

endpackage

// File: rtl/bus_reg_file.sv
// Host-visible register bank: write port, flattened view and read mux.
// With BUS_ERR_COUNT_EN the error counter is readable at ERR_CNT_IDX.
module bus_reg_file
  import bus_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [IDX_W-1:0]             widx,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [IDX_W-1:0]             ridx,
  input  logic [DATA_W-1:0]            status_in,
`ifdef BUS_ERR_COUNT_EN
  input  logic [CNT_W-1:0]             err_cnt,
`endif
  output logic [DATA_W-1:0]            rd_data_c,
  output logic                         rd_illegal_c,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

  // Index 0 is the live status word, so storage starts at 1.
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (widx == IDX_W'(i)) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  assign reg_q[DATA_W-1:0] = '0;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

  // Anything not matched below is an illegal index.
  always_comb begin
    rd_data_c    = BAD_ADDR_DATA;
    rd_illegal_c = 1'b1;
    if (ridx == '0) begin
      rd_data_c    = status_in;
      rd_illegal_c = 1'b0;
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ridx == IDX_W'(i)) begin
        rd_data_c    = regs[i];
        rd_illegal_c = 1'b0;
      end
    end
`ifdef BUS_ERR_COUNT_EN
    if (ridx == ERR_CNT_IDX) begin
      rd_data_c    = {(DATA_W-CNT_W)'(0), err_cnt};
      rd_illegal_c = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/bus_reg_port.sv
// Register-port stage behind the 32-bit bus handshake FSM: address latch,
// write capture, read drive and sticky error. BUS_ERR_COUNT_EN adds a counter.
module bus_reg_port
  import bus_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            bus_in,
  output logic [DATA_W-1:0]            bus_out,
  output logic                         bus_oe,
  input  logic                         handshake1_1,
  input  logic                         data_avail,
  input  logic                         read_word_from_BUS,
  input  logic                         write_word_to_BUS,
  output logic                         RW,
  input  logic [DATA_W-1:0]            status_in,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic                         wr_strobe,
  output logic [IDX_W-1:0]             wr_index,
  output logic                         err_flag
);

  localparam logic [IDX_W-1:0] NUM_REGS_IDX = IDX_W'(NUM_REGS);

  bus_port_state_t   state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] bus_out_d;
  logic              bus_oe_d;
  logic              wr_strobe_d;
  logic [IDX_W-1:0]  wr_index_d;
  logic              err_flag_d;
  logic              reg_we_c;
  logic              err_set_c;
  logic              err_clr_c;
  logic              wr_legal_c;
  logic [DATA_W-1:0] rd_data_c;
  logic              rd_illegal_c;

  // RW is live on the address cycle so the FSM can branch immediately.
  assign RW         = data_avail ? bus_in[RW_BIT] : rw_q;
  assign wr_legal_c = (idx_q != '0) && (idx_q < NUM_REGS_IDX);

`ifdef BUS_ERR_COUNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating illegal-access count, cleared together with err_flag.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr_c) begin
      err_cnt_d = '0;
    end else if (err_set_c && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

  bus_reg_file #(
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk          (clk),
    .reset        (reset),
    .we           (reg_we_c),
    .widx         (idx_q),
    .wdata        (bus_in),
    .ridx         (idx_q),
    .status_in    (status_in),
`ifdef BUS_ERR_COUNT_EN
    .err_cnt      (err_cnt_q),
`endif
    .rd_data_c    (rd_data_c),
    .rd_illegal_c (rd_illegal_c),
    .reg_q        (reg_q)
  );

  // Next-state and registered-output logic; a new address always aborts.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rw_d        = rw_q;
    bus_out_d   = bus_out;
    bus_oe_d    = bus_oe;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index;
    reg_we_c    = 1'b0;
    err_set_c   = 1'b0;
    err_clr_c   = 1'b0;

    if (data_avail) begin
      idx_d    = bus_in[IDX_W-1:0];
      rw_d     = bus_in[RW_BIT];
      bus_oe_d = 1'b0;
      state_d  = HAVE_ADDR;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        HAVE_ADDR: begin
          if (read_word_from_BUS) begin
            // Index 0 is the error-clear command, never a register.
            if (idx_q == '0) begin
              err_clr_c = bus_in[0];
            end else if (wr_legal_c) begin
              reg_we_c    = 1'b1;
              wr_strobe_d = 1'b1;
              wr_index_d  = idx_q;
            end else begin
              err_set_c = 1'b1;
            end
            state_d = IDLE;
          end else if (write_word_to_BUS) begin
            bus_out_d = rd_data_c;
            err_set_c = rd_illegal_c;
            bus_oe_d  = 1'b1;
            state_d   = DRIVE;
          end
        end
        DRIVE: begin
          if (!handshake1_1) begin
            bus_oe_d = 1'b0;
            state_d  = IDLE;
          end
        end
        default: begin
          bus_oe_d = 1'b0;
          state_d  = IDLE;
        end
      endcase
    end

    err_flag_d = err_flag;
    if (err_clr_c) begin
      err_flag_d = 1'b0;
    end else if (err_set_c) begin
      err_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rw_q      <= 1'b0;
      bus_out   <= '0;
      bus_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      err_flag  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rw_q      <= rw_d;
      bus_out   <= bus_out_d;
      bus_oe    <= bus_oe_d;
      wr_strobe <= wr_strobe_d;
      wr_index  <= wr_index_d;
      err_flag  <= err_flag_d;
    end
  end

endmodule

// File: tb/tb_bus_reg_port.sv
// Self-checking bench for bus_reg_port: vector table plus scoreboard for
// write strobes and read drives, with hand sequences for abort/reset cases.
module tb_bus_reg_port;

  localparam int NR = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     bus_in;
  logic [31:0]     bus_out;
  logic            bus_oe;
  logic            handshake1_1;
  logic            data_avail;
  logic            read_word_from_BUS;
  logic            write_word_to_BUS;
  logic            RW;
  logic [31:0]     status_in;
  logic [NR*32-1:0] reg_q;
  logic            wr_strobe;
  logic [7:0]      wr_index;
  logic            err_flag;

  always #5 clk = ~clk;

  bus_reg_port #(.NUM_REGS(NR)) dut (
    .clk                (clk),
    .reset              (reset),
    .bus_in             (bus_in),
    .bus_out            (bus_out),
    .bus_oe             (bus_oe),
    .handshake1_1       (handshake1_1),
    .data_avail         (data_avail),
    .read_word_from_BUS (read_word_from_BUS),
    .write_word_to_BUS  (write_word_to_BUS),
    .RW                 (RW),
    .status_in          (status_in),
    .reg_q              (reg_q),
    .wr_strobe          (wr_strobe),
    .wr_index           (wr_index),
    .err_flag           (err_flag)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd_sb[$];
  logic [7:0]  wr_idx_sb[$];
  logic [31:0] wr_dat_sb[$];
  logic [31:0] model [NR];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] status;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    f = '0;
    for (int i = 1; i < NR; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic host_write(input logic [31:0] a, input logic [31:0] d);
    data_avail = 1'b1;
    bus_in     = a;
    #1 chk("rw_on_addr", RW, a[31]);
    @(negedge clk);
    data_avail         = 1'b0;
    bus_in             = d;
    read_word_from_BUS = 1'b1;
    if (a[7:0] >= 8'd1 && a[7:0] < 8'(NR)) begin
      wr_idx_sb.push_back(a[7:0]);
      wr_dat_sb.push_back(d);
      model[a[7:0]] = d;
    end
    @(negedge clk);
    read_word_from_BUS = 1'b0;
    bus_in             = '0;
    @(negedge clk);
  endtask

  task automatic host_read(input logic [31:0] a, input logic [31:0] exp, input int hold);
    data_avail = 1'b1;
    bus_in     = a;
    #1 chk("rw_on_addr", RW, a[31]);
    @(negedge clk);
    data_avail        = 1'b0;
    bus_in            = '0;
    write_word_to_BUS = 1'b1;
    handshake1_1      = 1'b1;
    rd_sb.push_back(exp);
    @(negedge clk);
    write_word_to_BUS = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("oe_hold", bus_oe, 1'b1);
      chk("data_hold", bus_out, exp);
    end
    handshake1_1 = 1'b0;
    @(negedge clk);
    chk("oe_release", bus_oe, 1'b0);
  endtask

  initial begin
    reset              = 1'b1;
    bus_in             = '0;
    handshake1_1       = 1'b0;
    data_avail         = 1'b0;
    read_word_from_BUS = 1'b0;
    write_word_to_BUS  = 1'b0;
    status_in          = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    vt[0]  = '{32'h0000_0003, 32'h1234_5678, 32'h0,          32'h0,          1'b0};
    vt[1]  = '{32'h8000_0003, 32'h0,         32'h0,          32'h1234_5678, 1'b0};
    vt[2]  = '{32'h8000_0000, 32'h0,         32'hA5A5_0001, 32'hA5A5_0001, 1'b0};
    vt[3]  = '{32'h7FFF_FF02, 32'h55AA_55AA, 32'h0,          32'h0,          1'b0};
    vt[4]  = '{32'h80AB_CD02, 32'h0,         32'h0,          32'h55AA_55AA, 1'b0};
    vt[5]  = '{32'h0000_0007, 32'hCAFE_F00D, 32'h0,          32'h0,          1'b0};
    vt[6]  = '{32'h8000_0007, 32'h0,         32'h0,          32'hCAFE_F00D, 1'b0};
    vt[7]  = '{32'h0000_0001, 32'h0000_0001, 32'h0,          32'h0,          1'b0};
    vt[8]  = '{32'h8000_0009, 32'h0,         32'h0,          32'hDEAD_BEEF, 1'b1};
    vt[9]  = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h0,          32'h0,          1'b1};
    vt[10] = '{32'h0000_0000, 32'h0000_0001, 32'h0,          32'h0,          1'b0};
    vt[11] = '{32'h0000_0009, 32'hFFFF_FFFF, 32'h0,          32'h0,          1'b1};
    vt[12] = '{32'h8000_0001, 32'h0,         32'h0,          32'h0000_0001, 1'b1};
    vt[13] = '{32'h8000_0008, 32'h0,         32'h0,          32'hDEAD_BEEF, 1'b1};
    vt[14] = '{32'h0000_0000, 32'h0000_0001, 32'h0,          32'h0,          1'b0};
    vt[15] = '{32'h0000_0000, 32'h0000_0000, 32'h0,          32'h0,          1'b0};
    vt[16] = '{32'h8000_0000, 32'h0,         32'h0BAD_C0DE, 32'h0BAD_C0DE, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_bus_oe", bus_oe, 1'b0);
    chk("rst_bus_out", bus_out, 32'h0);
    chk("rst_wr_strobe", wr_strobe, 1'b0);
    chk("rst_wr_index", wr_index, 8'h0);
    chk("rst_err_flag", err_flag, 1'b0);
    chk("rst_rw", RW, 1'b0);
    chk("rst_reg_q", reg_q, '0);

    // Scoreboard monitor: pops on every strobe cycle and every drive start.
    fork
      begin
        logic oe_prev;
        oe_prev = 1'b0;
        forever begin
          @(negedge clk);
          if (wr_strobe) begin
            if (wr_idx_sb.size() == 0) begin
              chk("unexpected_wr_strobe", wr_strobe, 1'b0);
            end else begin
              logic [7:0]  ei;
              logic [31:0] ed;
              ei = wr_idx_sb.pop_front();
              ed = wr_dat_sb.pop_front();
              chk("wr_index", wr_index, ei);
              chk("wr_reg_slice", reg_q[ei*32 +: 32], ed);
            end
          end
          if (bus_oe && !oe_prev) begin
            if (rd_sb.size() == 0) begin
              chk("unexpected_bus_oe", bus_oe, 1'b0);
            end else begin
              chk("rd_bus_out", bus_out, rd_sb.pop_front());
            end
          end
          oe_prev = bus_oe;
        end
      end
    join_none

    for (int i = 0; i < 17; i++) begin
      status_in = vt[i].status;
      if (vt[i].addr[31]) host_read(vt[i].addr, vt[i].exp, 2);
      else                host_write(vt[i].addr, vt[i].data);
      chk("vec_err_flag", err_flag, vt[i].exp_err);
      chk("vec_reg_q", reg_q, model_flat());
    end

    // Capture and drive requested together: capture wins, no drive.
    data_avail = 1'b1;
    bus_in     = 32'h0000_0004;
    @(negedge clk);
    data_avail         = 1'b0;
    bus_in             = 32'h0BAD_F00D;
    read_word_from_BUS = 1'b1;
    write_word_to_BUS  = 1'b1;
    handshake1_1       = 1'b1;
    wr_idx_sb.push_back(8'd4);
    wr_dat_sb.push_back(32'h0BAD_F00D);
    model[4] = 32'h0BAD_F00D;
    @(negedge clk);
    read_word_from_BUS = 1'b0;
    write_word_to_BUS  = 1'b0;
    chk("both_no_oe", bus_oe, 1'b0);
    @(negedge clk);
    chk("both_no_oe_later", bus_oe, 1'b0);
    handshake1_1 = 1'b0;

    // Capture/drive strobes in IDLE are ignored.
    read_word_from_BUS = 1'b1;
    write_word_to_BUS  = 1'b1;
    bus_in             = 32'hFFFF_FFFF;
    @(negedge clk);
    read_word_from_BUS = 1'b0;
    write_word_to_BUS  = 1'b0;
    @(negedge clk);
    chk("idle_no_oe", bus_oe, 1'b0);
    chk("idle_reg_q", reg_q, model_flat());

    // New address while driving aborts the read and re-latches.
    data_avail = 1'b1;
    bus_in     = 32'h8000_0003;
    @(negedge clk);
    data_avail        = 1'b0;
    write_word_to_BUS = 1'b1;
    handshake1_1      = 1'b1;
    rd_sb.push_back(model[3]);
    @(negedge clk);
    write_word_to_BUS = 1'b0;
    @(negedge clk);
    data_avail = 1'b1;
    bus_in     = 32'h0000_0005;
    #1 chk("abort_rw", RW, 1'b0);
    @(negedge clk);
    data_avail = 1'b0;
    chk("abort_oe", bus_oe, 1'b0);
    bus_in             = 32'h5555_0005;
    read_word_from_BUS = 1'b1;
    wr_idx_sb.push_back(8'd5);
    wr_dat_sb.push_back(32'h5555_0005);
    model[5] = 32'h5555_0005;
    @(negedge clk);
    read_word_from_BUS = 1'b0;
    handshake1_1       = 1'b0;
    @(negedge clk);
    chk("abort_reg_q", reg_q, model_flat());

    // Reset in the middle of a drive.
    host_write(32'h0000_0009, 32'h1);
    chk("pre_rst_err", err_flag, 1'b1);
    data_avail = 1'b1;
    bus_in     = 32'h8000_0004;
    @(negedge clk);
    data_avail        = 1'b0;
    write_word_to_BUS = 1'b1;
    handshake1_1      = 1'b1;
    rd_sb.push_back(model[4]);
    @(negedge clk);
    write_word_to_BUS = 1'b0;
    reset             = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    handshake1_1 = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    chk("mid_rst_oe", bus_oe, 1'b0);
    chk("mid_rst_bus_out", bus_out, 32'h0);
    chk("mid_rst_wr_index", wr_index, 8'h0);
    chk("mid_rst_err", err_flag, 1'b0);
    chk("mid_rst_reg_q", reg_q, '0);
    @(negedge clk);
    chk("mid_rst_oe_stays", bus_oe, 1'b0);

`ifdef BUS_ERR_COUNT_EN
    host_read(32'h8000_0009, 32'hDEAD_BEEF, 0);
    host_write(32'h0000_000A, 32'h1);
    host_read(32'h8000_00FE, 32'hDEAD_BEEF, 0);
    host_read(32'h8000_00FF, 32'h0000_0003, 1);
    host_read(32'h8000_00FF, 32'h0000_0003, 0);
    chk("cnt_err_flag", err_flag, 1'b1);
    host_write(32'h0000_0000, 32'h1);
    host_read(32'h8000_00FF, 32'h0000_0000, 0);
    chk("cnt_clr_err", err_flag, 1'b0);
`else
    host_read(32'h8000_00FF, 32'hDEAD_BEEF, 0);
    chk("ff_illegal_err", err_flag, 1'b1);
`endif

    repeat (2) @(negedge clk);
    chk("rd_sb_empty", rd_sb.size(), 0);
    chk("wr_sb_empty", wr_idx_sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
